// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave engine.
// Mode encoding is {cpol, cpha}.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } spi_state_e;

  localparam int SPI_DATA_W_DEF      = 8;
  localparam int SPI_SYNC_STAGES_DEF = 2;

  localparam logic [1:0] SPI_MODE_0 = 2'b00;
  localparam logic [1:0] SPI_MODE_1 = 2'b01;
  localparam logic [1:0] SPI_MODE_2 = 2'b10;
  localparam logic [1:0] SPI_MODE_3 = 2'b11;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for asynchronous pins plus rise/fall strobes.
// Only the low EDGE_W bits get edge detection; the upper bits are level-only.
module spi_sync_edge #(
  parameter int               WIDTH   = 1,
  parameter int               EDGE_W  = 1,
  parameter int               STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [WIDTH-1:0]  i_async,
  output logic [WIDTH-1:0]  o_level,
  output logic [EDGE_W-1:0] o_rise,
  output logic [EDGE_W-1:0] o_fall
);

  logic [WIDTH-1:0]  r_sync [STAGES];
  logic [EDGE_W-1:0] r_prev;
  logic [EDGE_W-1:0] w_edge_level;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < STAGES; i++) r_sync[i] <= RST_VAL;
      r_prev <= RST_VAL[EDGE_W-1:0];
    end else begin
      r_sync[0] <= i_async;
      for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= r_sync[STAGES-1][EDGE_W-1:0];
    end
  end

  assign o_level      = r_sync[STAGES-1];
  assign w_edge_level = r_sync[STAGES-1][EDGE_W-1:0];
  assign o_rise       = w_edge_level & ~r_prev;
  assign o_fall       = ~w_edge_level & r_prev;

endmodule

// File: rtl/spi_slave_engine.sv
// SPI slave shifter: pins in, words out to the register/FIFO layer (full duplex, MSB first).
// Define SPI_SLAVE_MODE_SEL_EN to add i_cpol/i_cpha; without it the block is fixed at mode 0.
module spi_slave_engine
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W_DEF,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_sck,
  input  logic              i_ss_n,
  input  logic              i_mosi,
  output logic              o_miso,
  output logic              o_miso_oe,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  output logic              o_tx_underrun,
  output logic              o_frame_abort
`ifdef SPI_SLAVE_MODE_SEL_EN
  ,
  input  logic              i_cpol,
  input  logic              i_cpha
`endif
);

  localparam int               CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  spi_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_tx_shift, r_rx_shift, r_rx_data, r_hold, w_rx_next;
  logic              r_hold_full, r_first, r_rx_valid, r_underrun, r_abort;
  logic [2:0]        w_level;
  logic [1:0]        w_rise, w_fall, w_mode;
  logic              w_sck_level, w_ss_level, w_mosi, w_sck_edge, w_ss_rise, w_ss_fall;
  logic              w_cpol, w_cpha, w_lead, w_trail, w_active, w_sample, w_shift;
  logic              w_word_start, w_boundary, w_hold_msb, w_load, w_capture, w_last, w_abort;

  spi_sync_edge #(
    .WIDTH  (3),
    .EDGE_W (2),
    .STAGES (SYNC_STAGES),
    .RST_VAL(3'b010)
  ) u_sync (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_async({i_mosi, i_ss_n, i_sck}),
    .o_level(w_level),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_sck_level = w_level[0];
  assign w_ss_level  = w_level[1];
  assign w_mosi      = w_level[2];
  assign w_sck_edge  = w_rise[0] | w_fall[0];
  assign w_ss_rise   = w_rise[1];
  assign w_ss_fall   = w_fall[1];

`ifdef SPI_SLAVE_MODE_SEL_EN
  logic [1:0] r_mode;
  // Mode is frozen for the whole frame at the moment the frame starts.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_mode <= SPI_MODE_0;
    else if (r_state == ST_IDLE && w_ss_fall) r_mode <= {i_cpol, i_cpha};
  end
  assign w_mode = r_mode;
`else
  assign w_mode = SPI_MODE_0;
`endif

  assign w_cpol = w_mode[1];
  assign w_cpha = w_mode[0];

  assign w_lead       = w_sck_edge && (w_sck_level != w_cpol);
  assign w_trail      = w_sck_edge && (w_sck_level == w_cpol);
  assign w_active     = (r_state == ST_SHIFT) && !w_ss_rise;
  assign w_sample     = w_active && (w_cpha ? w_trail : w_lead);
  assign w_shift      = w_active && (w_cpha ? w_lead : w_trail);
  assign w_last       = (r_bit_cnt == LAST_BIT);
  assign w_rx_next    = {r_rx_shift[DATA_W-2:0], w_mosi};
  // A shift edge with the counter at zero starts a new word; in cpha=1 the
  // first such edge of a frame only presents the word LOAD already fetched.
  assign w_word_start = w_shift && (r_bit_cnt == '0);
  assign w_boundary   = w_word_start && !r_first;
  assign w_hold_msb   = w_word_start && r_first;
  assign w_load       = ((r_state == ST_LOAD) && !w_ss_rise) || w_boundary;
  assign w_capture    = i_tx_valid && !r_hold_full;
  assign w_abort      = w_ss_rise && (r_bit_cnt != '0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_ss_fall) w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = ST_SHIFT;
      ST_SHIFT: w_state_nxt = ST_SHIFT;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (w_ss_rise || !i_enable) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_abort    <= 1'b0;
    end else if (!i_enable) begin
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_rx_valid <= w_sample && w_last;
      r_abort    <= w_abort;
      if (w_ss_rise || r_state == ST_IDLE) begin
        r_bit_cnt <= '0;
      end else if (w_sample) begin
        r_rx_shift <= w_rx_next;
        if (w_last) begin
          r_rx_data <= w_rx_next;
          r_bit_cnt <= '0;
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_tx_shift <= '0;
      r_first    <= 1'b0;
      r_underrun <= 1'b0;
    end else if (!i_enable) begin
      r_tx_shift <= '0;
      r_first    <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_load && !r_hold_full;
      if (w_load)                    r_tx_shift <= r_hold_full ? r_hold : '0;
      else if (w_shift && !w_hold_msb) r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
      if (r_state == ST_LOAD) r_first <= 1'b1;
      else if (w_shift)       r_first <= 1'b0;
    end
  end

  // Capture only happens while empty, so a same-cycle load sends the old
  // (empty) contents and the newly written word stays in the holding register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (!i_enable) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_capture) begin
      r_hold      <= i_tx_data;
      r_hold_full <= 1'b1;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end
  end

  assign o_miso        = r_tx_shift[DATA_W-1];
  assign o_miso_oe     = (r_state != ST_IDLE) && !w_ss_level;
  assign o_tx_ready    = !r_hold_full;
  assign o_rx_data     = r_rx_data;
  assign o_rx_valid    = r_rx_valid;
  assign o_tx_underrun = r_underrun;
  assign o_frame_abort = r_abort;

endmodule

// File: tb/tb_spi_slave_engine.sv
// Self-checking bench for spi_slave_engine: a behavioural SPI master plus word-level model.
// Covers mode 3 and random modes when SPI_SLAVE_MODE_SEL_EN is defined.
module tb_spi_slave_engine;

  localparam int HALF = 60;

  logic       clk = 1'b0;
  logic       reset, enable, sck, ss_n, mosi, tx_valid;
  logic [7:0] tx_data;
  logic       miso, miso_oe, tx_ready, rx_valid, tx_underrun, frame_abort;
  logic [7:0] rx_data;
  bit         m_cpol, m_cpha;
`ifdef SPI_SLAVE_MODE_SEL_EN
  logic       cpol, cpha;
`endif

  always #5 clk = ~clk;

  spi_slave_engine dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_enable     (enable),
    .i_sck        (sck),
    .i_ss_n       (ss_n),
    .i_mosi       (mosi),
    .o_miso       (miso),
    .o_miso_oe    (miso_oe),
    .i_tx_data    (tx_data),
    .i_tx_valid   (tx_valid),
    .o_tx_ready   (tx_ready),
    .o_rx_data    (rx_data),
    .o_rx_valid   (rx_valid),
    .o_tx_underrun(tx_underrun),
    .o_frame_abort(frame_abort)
`ifdef SPI_SLAVE_MODE_SEL_EN
    ,
    .i_cpol       (cpol),
    .i_cpha       (cpha)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] feed_q[$], mosi_q[$], m_rx_q[$], rx_q[$], exp_rx_q[$], exp_miso_q[$];
  int cnt_underrun = 0, cnt_abort = 0, sck_falls = 0, miso_hi_chg = 0, miso_lo_chg = 0;
  int rx_base, u_base, a_base, f0;
  bit watch3 = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Upstream writer: presents queued words with valid/ready.
  initial begin
    logic vld, rdy;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (feed_q.size() > 0) begin
        tx_data  = feed_q[0];
        tx_valid = 1'b1;
      end else begin
        tx_valid = 1'b0;
      end
      vld = tx_valid;
      rdy = tx_ready;
      @(posedge clk);
      if (vld && rdy) void'(feed_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rx_valid) rx_q.push_back(rx_data);
    if (tx_underrun) cnt_underrun++;
    if (frame_abort) cnt_abort++;
  end

  always @(negedge sck) sck_falls++;

  always @(miso) begin
    if (watch3 && ss_n == 1'b0 && sck_falls != f0) begin
      if (sck) miso_hi_chg++;
      else     miso_lo_chg++;
    end
  end

  // SPI master: shifts mosi_q out MSB first, collects miso words into m_rx_q.
  task automatic spi_frame(input int nbits, input bit raise);
    logic [7:0] ob, ib;
    ob      = 8'h00;
    ib      = 8'h00;
    rx_base = rx_q.size();
    u_base  = cnt_underrun;
    a_base  = cnt_abort;
    f0      = sck_falls;
    @(negedge clk);
    ss_n = 1'b0;
    #(HALF);
    for (int i = 0; i < nbits; i++) begin
      if (i % 8 == 0) ob = (mosi_q.size() > 0) ? mosi_q.pop_front() : 8'h00;
      if (!m_cpha) begin
        mosi = ob[7];
        ob   = {ob[6:0], 1'b0};
        #(HALF);
        sck = ~m_cpol;
        ib  = {ib[6:0], miso};
        #(HALF);
        sck = m_cpol;
        if (raise && i == nbits - 1) ss_n = 1'b1;
      end else begin
        sck  = ~m_cpol;
        mosi = ob[7];
        ob   = {ob[6:0], 1'b0};
        #(HALF);
        sck = m_cpol;
        ib  = {ib[6:0], miso};
        #(HALF);
      end
      if (i % 8 == 7) m_rx_q.push_back(ib);
    end
    if (raise) ss_n = 1'b1;
    #(2 * HALF);
  endtask

  task automatic wait_fed(input int left);
    for (int i = 0; i < 40 && feed_q.size() > left; i++) @(negedge clk);
    check_eq("feed_accept", feed_q.size() <= left, 1);
  endtask

  task automatic verify_frame(input string tag, input int exp_under, input int exp_abort);
    repeat (4) @(negedge clk);
    check_eq({tag, " rx_count"}, rx_q.size() - rx_base, exp_rx_q.size());
    foreach (exp_rx_q[i])
      check_eq({tag, " rx_word"}, (rx_base + i < rx_q.size()) ? {24'h0, rx_q[rx_base + i]} : 32'hFFFF_FFFF,
               exp_rx_q[i]);
    check_eq({tag, " miso_count"}, m_rx_q.size(), exp_miso_q.size());
    foreach (exp_miso_q[i])
      check_eq({tag, " miso_word"}, (i < m_rx_q.size()) ? {24'h0, m_rx_q[i]} : 32'hFFFF_FFFF, exp_miso_q[i]);
    check_eq({tag, " underruns"}, cnt_underrun - u_base, exp_under);
    check_eq({tag, " aborts"}, cnt_abort - a_base, exp_abort);
    check_eq({tag, " miso_oe_idle"}, miso_oe, 1'b0);
    exp_rx_q.delete();
    exp_miso_q.delete();
    m_rx_q.delete();
    mosi_q.delete();
  endtask

  // Queue one full-duplex word: slave sends tx (or 0 if not fed), master sends rx.
  task automatic add_word(input logic [7:0] tx, input logic [7:0] rx, input bit fed);
    if (fed) feed_q.push_back(tx);
    exp_miso_q.push_back(fed ? tx : 8'h00);
    mosi_q.push_back(rx);
    exp_rx_q.push_back(rx);
  endtask

`ifdef SPI_SLAVE_MODE_SEL_EN
  task automatic set_mode(input logic [1:0] md);
    m_cpol = md[1];
    m_cpha = md[0];
    cpol   = md[1];
    cpha   = md[0];
    sck    = md[1];
    repeat (8) @(negedge clk);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    sck    = 1'b0;
    ss_n   = 1'b1;
    mosi   = 1'b0;
    m_cpol = 1'b0;
    m_cpha = 1'b0;
`ifdef SPI_SLAVE_MODE_SEL_EN
    cpol = 1'b0;
    cpha = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_eq("rst miso", miso, 1'b0);
    check_eq("rst miso_oe", miso_oe, 1'b0);
    check_eq("rst tx_ready", tx_ready, 1'b1);
    check_eq("rst rx_data", rx_data, 8'h00);
    check_eq("rst rx_valid", rx_valid, 1'b0);
    check_eq("rst underrun", tx_underrun, 1'b0);
    check_eq("rst abort", frame_abort, 1'b0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    add_word(8'hA5, 8'h3C, 1'b1);
    wait_fed(0);
    spi_frame(8, 1'b1);
    verify_frame("mode0_single", 0, 0);
    check_eq("rx_data_held", rx_data, 8'h3C);

    add_word(8'h81, 8'h5A, 1'b1);
    add_word(8'h7E, 8'hC6, 1'b1);
    wait_fed(1);
    spi_frame(16, 1'b1);
    verify_frame("back_to_back", 0, 0);

    add_word(8'hFF, 8'h99, 1'b0);
    spi_frame(8, 1'b1);
    verify_frame("underrun", 1, 0);

    feed_q.push_back(8'hE7);
    mosi_q.push_back(8'hB4);
    wait_fed(0);
    spi_frame(5, 1'b1);
    verify_frame("abort5", 0, 1);
    add_word(8'h2D, 8'h55, 1'b1);
    wait_fed(0);
    spi_frame(8, 1'b1);
    verify_frame("after_abort", 0, 0);

    feed_q.push_back(8'h11);
    wait_fed(0);
    check_eq("hold_full_ready", tx_ready, 1'b0);
    enable = 1'b0;
    @(negedge clk);
    check_eq("disable_ready", tx_ready, 1'b1);
    enable = 1'b1;
    repeat (2) @(negedge clk);

`ifdef SPI_SLAVE_MODE_SEL_EN
    set_mode(2'b11);
    add_word(8'hC3, 8'h96, 1'b1);
    wait_fed(0);
    watch3 = 1'b1;
    begin
      int hi0, lo0;
      hi0 = miso_hi_chg;
      lo0 = miso_lo_chg;
      spi_frame(8, 1'b1);
      watch3 = 1'b0;
      check_eq("mode3 miso_chg_sck_high", miso_hi_chg - hi0, 0);
      check_eq("mode3 miso_chg_seen", (miso_lo_chg - lo0) > 0, 1);
    end
    verify_frame("mode3", 0, 0);
`endif

    for (int f = 0; f < 6; f++) begin
      int nw;
      nw = $urandom_range(1, 3);
`ifdef SPI_SLAVE_MODE_SEL_EN
      set_mode(2'($urandom_range(0, 3)));
`endif
      for (int w = 0; w < nw; w++) add_word(8'($urandom), 8'($urandom), 1'b1);
      wait_fed(nw - 1);
      spi_frame(nw * 8, 1'b1);
      verify_frame("random", 0, 0);
      check_eq("random fed_all", feed_q.size(), 0);
    end

`ifdef SPI_SLAVE_MODE_SEL_EN
    set_mode(2'b00);
`endif
    feed_q.push_back(8'h3A);
    mosi_q.push_back(8'hF0);
    wait_fed(0);
    spi_frame(4, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    check_eq("midrst miso", miso, 1'b0);
    check_eq("midrst miso_oe", miso_oe, 1'b0);
    check_eq("midrst tx_ready", tx_ready, 1'b1);
    check_eq("midrst rx_data", rx_data, 8'h00);
    check_eq("midrst rx_valid", rx_valid, 1'b0);
    check_eq("midrst underrun", tx_underrun, 1'b0);
    check_eq("midrst abort", frame_abort, 1'b0);
    ss_n = 1'b1;
    sck  = m_cpol;
    mosi_q.delete();
    m_rx_q.delete();
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    add_word(8'h6B, 8'hD2, 1'b1);
    wait_fed(0);
    spi_frame(8, 1'b1);
    verify_frame("after_reset", 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_slave_engine.md
# spi_slave_engine

Serial-side responder for the SPI IP core. It receives the externally supplied SCK, SS_n and MOSI, synchronizes them into the system clock domain, and shifts 8-bit words in and out. Words move in full-duplex and MSB first. It is the peer of the master-side baud divider / shifter: it sits between the SPI pins and the core's register/FIFO layer, which uses valid/ready on transmit and a strobe on receive.

## Interface
Parameters:
- DATA_W, 8, word length in bits (≥ 4).
- SYNC_STAGES, 2, synchronizer flops on sck/ss_n/mosi (≥ 2).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  0 = block held idle, same as reset but synchronous.
- sck  in  1  SPI clock from master, asynchronous.
- ss_n  in  1  slave select, active-low, asynchronous.
- mosi  in  1  serial data in, asynchronous.
- miso  out  1  serial data out.
- miso_oe  out  1  output enable for the miso pad; 1 while selected.
- tx_data  in  DATA_W  next word to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  the one-entry holding register is empty.
- rx_data  out  DATA_W  last received word; held until the next word.
- rx_valid  out  1  one-cycle strobe: rx_data has been updated.
- tx_underrun  out  1  one-cycle strobe: a word started with the holding register empty.
- frame_abort  out  1  one-cycle strobe: ss_n deasserted with 1..DATA_W-1 bits received.
- cpol, cpha  in  1 each  SPI mode select; present only with SPI_SLAVE_MODE_SEL_EN.

## Operation
- sck, ss_n and mosi each pass through SYNC_STAGES flops. One further register on sck gives edge detection.
- Lead edge = first sck transition away from idle level cpol. Trail edge = the opposite transition.
- Sample edge:
  - cpha=0: lead edge.
  - cpha=1: trail edge.
- Shift edge: the other one of the two.
- FSM states: IDLE, LOAD, SHIFT.
  - IDLE: miso_oe=0, bit counter=0. Synchronized ss_n falling goes to LOAD.
  - LOAD (one cycle): the holding register moves to the shift register and tx_ready rises. If the holding register is empty, the shift register loads all-zeros and tx_underrun pulses. miso_oe=1. Goes to SHIFT.
  - SHIFT:
    - Each sample edge shifts the synchronized mosi in at the LSB and increments the counter.
    - On the DATA_W-th sample: rx_data is updated, rx_valid pulses, and the counter wraps to 0.
    - Each shift edge shifts the shift register left, and miso takes the new MSB. Exception: at a word boundary the holding register is loaded instead, with the same underrun rule as LOAD.
    - Word boundary for cpha=0: the shift edge after the DATA_W-th sample.
    - Word boundary for cpha=1: the first shift edge of each word after the first. The first word was already loaded in LOAD, so its first lead edge just holds the MSB.
  - Synchronized ss_n rising in any state goes to IDLE, and miso_oe drops the same cycle. If the counter is non-zero, frame_abort pulses and the partial word is discarded (no rx_valid).
- miso = MSB of the shift register at all times; don't-care when miso_oe=0.
- Holding register: a tx_valid && tx_ready cycle captures tx_data and clears tx_ready. It is emptied by LOAD or by a word-boundary load. If capture and empty happen in the same cycle, the old contents go out and the new word is kept.
- A sample edge and ss_n rising in the same cycle: ss_n wins, and the sample is ignored.
- enable=0: IDLE, holding register emptied, tx_ready=1.

## Timing
- Reset values:
  - miso=0, miso_oe=0
  - tx_ready=1
  - rx_data=0
  - rx_valid=0, tx_underrun=0, frame_abort=0
  - FSM=IDLE
- Pin-to-action latency: SYNC_STAGES+1 clk cycles. rx_valid is asserted on the cycle after the DATA_W-th sample edge is detected.
- Requirements on the master:
  - sck high and low phases each ≥ SYNC_STAGES+2 clk periods.
  - ss_n falling to first lead edge ≥ SYNC_STAGES+3 clk periods.
- miso changes at most SYNC_STAGES+2 clk cycles after a pin shift edge.
- tx_ready rises no more than 1 cycle after a load. The next word must be written before the next word boundary, or an underrun occurs.

## Configuration
- SPI_SLAVE_MODE_SEL_EN defined: cpol/cpha ports exist. They are sampled into registers when the FSM leaves IDLE and stay constant for the frame.
- Not defined: no cpol/cpha ports; the block is fixed at mode 0 (cpol=0, cpha=0).

## Structure
- Shared package spi_pkg holds:
  - the FSM state typedef (IDLE/LOAD/SHIFT);
  - default DATA_W and SYNC_STAGES constants;
  - mode encoding constants.
- One sub-module: spi_sync_edge. It contains the SYNC_STAGES synchronizer and the edge detector, and outputs the level plus rise/fall strobes. It is instantiated for sck and ss_n; mosi uses the level output only.

## Test plan
- Mode 0, tx_data=0xA5 preloaded, master sends 0x3C: rx_data=0x3C with one rx_valid strobe, and the master receives 0xA5.
- Two back-to-back words with 0x81 then 0x7E written via valid/ready during word 1: master receives 0x81,0x7E, and there are no tx_underrun pulses.
- No tx_valid before ss_n falls: tx_underrun pulses once, and the master receives 0x00.
- ss_n deasserted after 5 bits: frame_abort pulses, there is no rx_valid, miso_oe=0, and the next frame with 0x55 is received correctly.
- With the macro, mode 3 (cpol=1, cpha=1), tx 0xC3, rx 0x96: both words correct, and miso changes only on falling sck.
- Reset asserted mid-word (bit 4): all outputs take their reset values asynchronously, and the next full frame completes normally.
